// File: rtl/sram_like_responder.sv
// ---------------------------------------------------------------------------
// sram_like_responder
//
// Target-side end of the sram-like memory interface. Requests are accepted
// with addr_ok, queued in order in a small FIFO, and each one is served from
// an internal word RAM a fixed number of edges after it reaches the FIFO head.
// Each request gets exactly one data_ok pulse, in order.
//
// Parameters:
//   ADDR_W     word-index width; the RAM holds 2^ADDR_W 32-bit words
//   LATENCY    edges from a request becoming FIFO head to its data_ok (1..15)
//   FIFO_DEPTH outstanding accepted requests (power of two, >= 2)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   req      request valid
//   wr       1 = write, 0 = read
//   size     0 = byte, 1 = half, 2/3 = word
//   addr     physical byte address (upper bits alias)
//   wdata    lane-aligned write data
//   addr_ok  request accepted this cycle (req && !full)
//   rdata    read word, valid while data_ok = 1 (0 for writes)
//   data_ok  one-cycle completion pulse per accepted request
// ---------------------------------------------------------------------------
module sram_like_responder #(
    parameter int ADDR_W     = 10,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W+1:0] addr;
        logic [31:0]       wdata;
    } entry_t;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Request FIFO storage; pointers carry one extra bit for full/empty.
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic [PTR_W:0]   occupancy;
    logic             full;
    logic             accept;
    entry_t           head;
    entry_t           push_entry;

    state_t           state_reg;
    state_t           state_next;
    logic [3:0]       cnt_reg;
    logic [3:0]       cnt_next;
    logic             pop;
    logic             data_ok_reg;

    logic [ADDR_W-1:0] head_idx;
    logic [3:0]        lane_we;

    // Upper address bits deliberately alias the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:ADDR_W+2]};

    // Full depends only on registered pointers, never on a same-cycle pop.
    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign full      = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign addr_ok   = req && !full;
    assign accept    = addr_ok;

    assign push_entry = '{wr: wr, size: size, addr: addr[ADDR_W+1:0], wdata: wdata};
    assign head       = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_idx   = head.addr[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= push_entry;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            data_ok_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            data_ok_reg <= pop;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                // FIFO is empty here, so any accept becomes the head at once.
                if (accept) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    pop = 1'b1;
                    // Another entry remains if more than one was queued or
                    // one is being pushed on this same edge.
                    if ((occupancy > (PTR_W+1)'(1)) || accept) begin
                        cnt_next = CNT_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // ---------------- byte enables ----------------
    // Misaligned half/word writes produce no enables, so the RAM is untouched.
    always_comb begin
        lane_we = 4'b0000;
        if (head.wr) begin
            case (head.size)
                2'd0: lane_we = 4'b0001 << head.addr[1:0];
                2'd1: begin
                    if (!head.addr[0]) begin
                        lane_we = head.addr[1] ? 4'b1100 : 4'b0011;
                    end
                end
                default: begin
                    if (head.addr[1:0] == 2'b00) begin
                        lane_we = 4'b1111;
                    end
                end
            endcase
        end
    end

    // ---------------- RAM, one byte-wide array per lane ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [2**ADDR_W];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (pop && lane_we[gi]) begin
                    mem[head_idx] <= head.wdata[8*gi +: 8];
                end
            end

            // Registered read; writes complete with zero read data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_byte_reg <= 8'h00;
                end else if (pop) begin
                    rd_byte_reg <= head.wr ? 8'h00 : mem[head_idx];
                end
            end
        end
    endgenerate

    assign rdata   = {g_lane[3].rd_byte_reg, g_lane[2].rd_byte_reg,
                      g_lane[1].rd_byte_reg, g_lane[0].rd_byte_reg};
    assign data_ok = data_ok_reg;

endmodule

// File: tb/tb_sram_like_responder.sv
// ---------------------------------------------------------------------------
// Bench for sram_like_responder. A transaction-level model (queue of pending
// requests with computed completion edges, word-addressed associative memory)
// predicts addr_ok, data_ok and rdata every cycle; directed tests add literal
// expectations on timing and read data.
// ---------------------------------------------------------------------------
module tb_sram_like_responder;

    localparam int ADDR_W     = 10;
    localparam int LAT        = 3;
    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    sram_like_responder #(
        .ADDR_W(ADDR_W), .LATENCY(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .rdata(rdata), .data_ok(data_ok)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        int          done;   // edge at which this request is executed
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] mmem [int unsigned];
    logic        exp_dok = 1'b0;
    logic [31:0] exp_rd = 32'd0;
    int          obs_edge[$];
    logic [31:0] obs_rd[$];

    always @(negedge clk) begin
        int    e;
        int    nb;
        int    lo;
        int    tail_done;
        bit    acc;
        bit    have_tail;
        int unsigned idx;
        logic [31:0] word;
        mreq_t r;
        mreq_t nr;

        // check this cycle's outputs
        chk("data_ok", {31'd0, data_ok}, {31'd0, (rst ? 1'b0 : exp_dok)});
        if (!rst && exp_dok) chk("rdata", rdata, exp_rd);
        chk("addr_ok", {31'd0, addr_ok}, {31'd0, (req && (mq.size() < FIFO_DEPTH))});
        if (data_ok) begin
            obs_edge.push_back(cyc);
            obs_rd.push_back(rdata);
        end

        // predict effect of the coming edge
        if (rst) begin
            mq.delete();
            exp_dok = 1'b0;
            exp_rd  = 32'd0;
        end else begin
            e         = cyc + 1;
            acc       = req && (mq.size() < FIFO_DEPTH);
            have_tail = (mq.size() > 0);
            tail_done = have_tail ? mq[$].done : 0;
            exp_dok   = 1'b0;
            if (mq.size() > 0 && mq[0].done == e) begin
                r   = mq.pop_front();
                idx = (r.a >> 2) % (1 << ADDR_W);
                if (r.w) begin
                    nb = (r.s == 2'd0) ? 1 : (r.s == 2'd1) ? 2 : 4;
                    if ((r.a % nb) == 0) begin
                        word = mmem.exists(idx) ? mmem[idx] : 32'd0;
                        lo   = int'(r.a % 4);
                        for (int b = lo; b < lo + nb; b++) word[8*b +: 8] = r.d[8*b +: 8];
                        mmem[idx] = word;
                    end
                    exp_rd = 32'd0;
                end else begin
                    exp_rd = mmem.exists(idx) ? mmem[idx] : 32'd0;
                end
                exp_dok = 1'b1;
            end
            if (acc) begin
                nr.w = wr; nr.s = size; nr.a = addr; nr.d = wdata;
                nr.done = (have_tail ? tail_done : e) + LAT;
                mq.push_back(nr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int t);
        bit done = 0;
        req = 1'b1; wr = w; size = s; addr = a; wdata = d; t = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            done = addr_ok;
            @(posedge clk);
            #1;
        end
        chk("accepted", {31'd0, done}, 32'd1);
        if (done) t = cyc;
        req = 1'b0;
        $display("[TB] req wr=%0d size=%0d addr=%h wdata=%h accepted at edge %0d", w, s, a, d, t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_edge.delete();
        obs_rd.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle addr_ok", {31'd0, addr_ok}, 32'd0);
            chk("idle data_ok", {31'd0, data_ok}, 32'd0);
            chk("idle rdata", rdata, 32'd0);
        end
        @(posedge clk); #1;

        // Word write then back-to-back read
        clear_obs();
        issue(1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, t0);
        issue(1'b0, 2'd2, 32'h0000_0010, 32'h0, t1);
        idle(3 * LAT + 4);
        chk("wr_rd t1", t1, t0 + 1);
        chk("wr_rd count", obs_edge.size(), 2);
        if (obs_edge.size() == 2) begin
            chk("wr dok edge", obs_edge[0], t0 + LAT);
            chk("rd dok edge", obs_edge[1], t0 + 2 * LAT);
            chk("wr rdata", obs_rd[0], 32'h0);
            chk("rd rdata", obs_rd[1], 32'hDEAD_BEEF);
        end

        // Byte/half merge
        clear_obs();
        issue(1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344, t0);
        issue(1'b1, 2'd0, 32'h0000_0021, 32'h0000_AA00, t0);
        issue(1'b1, 2'd1, 32'h0000_0022, 32'hBBCC_0000, t0);
        issue(1'b0, 2'd0, 32'h0000_0020, 32'h0, t0);
        idle(5 * LAT + 4);
        chk("merge count", obs_rd.size(), 4);
        if (obs_rd.size() == 4) chk("merge rdata", obs_rd[3], 32'hBBCC_AA44);

        // Misaligned writes suppressed but still completed
        clear_obs();
        issue(1'b1, 2'd2, 32'h0000_0030, 32'h1234_5678, t0);
        issue(1'b1, 2'd2, 32'h0000_0032, 32'hFFFF_FFFF, t0);
        issue(1'b1, 2'd1, 32'h0000_0031, 32'hFFFF_FFFF, t0);
        issue(1'b0, 2'd2, 32'h0000_0030, 32'h0, t0);
        idle(5 * LAT + 4);
        chk("misalign count", obs_rd.size(), 4);
        if (obs_rd.size() == 4) chk("misalign rdata", obs_rd[3], 32'h1234_5678);

        // Address aliasing and top word
        clear_obs();
        issue(1'b1, 2'd2, 32'h0000_0044, 32'hCAFE_F00D, t0);
        issue(1'b0, 2'd2, 32'h0000_1044, 32'h0, t0);
        issue(1'b1, 2'd2, 32'h8000_0FFC, 32'h0BAD_CAFE, t0);
        issue(1'b0, 2'd3, 32'h0000_0FFC, 32'h0, t0);
        idle(5 * LAT + 4);
        chk("alias count", obs_rd.size(), 4);
        if (obs_rd.size() == 4) begin
            chk("alias rdata", obs_rd[1], 32'hCAFE_F00D);
            chk("top rdata", obs_rd[3], 32'h0BAD_CAFE);
        end

        // Backpressure: three reads with req held
        clear_obs();
        issue(1'b0, 2'd2, 32'h0000_0010, 32'h0, t1);
        issue(1'b0, 2'd2, 32'h0000_0020, 32'h0, t2);
        issue(1'b0, 2'd2, 32'h0000_0030, 32'h0, t3);
        idle(4 * LAT + 4);
        chk("bp t2", t2, t1 + 1);
        chk("bp t3", t3, t1 + LAT + 1);
        chk("bp count", obs_edge.size(), 3);
        if (obs_edge.size() == 3) begin
            chk("bp dok0", obs_edge[0], t1 + LAT);
            chk("bp dok1", obs_edge[1], t1 + 2 * LAT);
            chk("bp dok2", obs_edge[2], t1 + 3 * LAT);
            chk("bp rd0", obs_rd[0], 32'hDEAD_BEEF);
            chk("bp rd1", obs_rd[1], 32'hBBCC_AA44);
            chk("bp rd2", obs_rd[2], 32'h1234_5678);
        end

        // Reset mid-flight flushes a pending write
        clear_obs();
        issue(1'b1, 2'd2, 32'h0000_0030, 32'h5555_5555, t0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        $display("[TB] reset pulse applied after accept at edge %0d", t0);
        idle(3 * LAT + 4);
        chk("flush no data_ok", obs_edge.size(), 0);
        clear_obs();
        issue(1'b0, 2'd2, 32'h0000_0030, 32'h0, t0);
        idle(LAT + 4);
        chk("flush count", obs_rd.size(), 1);
        if (obs_rd.size() == 1) chk("flush old value", obs_rd[0], 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Target-side (responder) end of the CPU's sram-like memory interface. It sits behind the address-translation stage and receives physical addresses only.
- Accepts requests with an addr_ok handshake and queues them in order in a small FIFO.
- Serves each request from an internal word RAM after a fixed latency, and returns completion with a one-cycle data_ok pulse.
- Used as instruction or data memory in simulation SoCs and as the template for real bus bridges.

Parameters:
- ADDR_W, 10, word-index width; RAM holds 2^ADDR_W 32-bit words.
- LATENCY, 2, edges from a request becoming FIFO head to data_ok; legal range 1..15.
- FIFO_DEPTH, 2, outstanding accepted requests; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- addr  in  32  physical byte address.
- wdata  in  32  write data, lane-aligned (byte n on bits 8n+7:8n).
- addr_ok  out  1  request accepted this cycle.
- rdata  out  32  read word; valid only while data_ok = 1.
- data_ok  out  1  one-cycle completion pulse, one per accepted request, in order.

Behaviour:
Reset and accept:
- Reset is asynchronous and active-high. Reset values: data_ok = 0, rdata = 0, FIFO empty, state IDLE, counter 0. RAM contents are not reset.
- addr_ok = req && !fifo_full. It is combinational from req and a registered full flag, with no dependence on a same-cycle retire.
- A request is accepted at a rising edge where req && addr_ok. Its {wr, size, addr[ADDR_W+1:0], wdata} is pushed into the FIFO.

Addressing:
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so the RAM aliases across the physical space.

State machine (IDLE, WAIT; 4-bit counter cnt):
- IDLE: FIFO empty. On an accept edge, go to WAIT with cnt = LATENCY-1.
- WAIT, cnt != 0: cnt decrements each edge.
- WAIT, cnt == 0: on this edge the head request is executed.
  - Set data_ok = 1 for the following cycle.
  - For a read, rdata = mem[idx]. For a write, rdata = 0.
  - Pop the head.
  - If the FIFO stays non-empty after the pop (including an entry pushed on this same edge), stay in WAIT and reload cnt = LATENCY-1. Otherwise go to IDLE.
- In every other cycle data_ok = 0.

Latency and throughput:
- An isolated request accepted at edge T sees data_ok high in the cycle after edge T+LATENCY.
- Sustained throughput is one response per LATENCY cycles.

Writes and ordering:
- Byte enables come from size and addr[1:0]:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
- Misaligned half (addr[0] = 1) or word (addr[1:0] != 0) writes are suppressed, with no RAM change. data_ok is still returned.
- Reads always return the full aligned word regardless of size; the requester extracts the bytes.
- Ordering is strictly FIFO, so a read accepted after a write to the same word returns the new data.

Boundary conditions:
- Full FIFO: addr_ok = 0 even if the head retires on the same edge. The requester holds req and its fields stable until accepted.
- Simultaneous push and pop when not full: both take effect and the occupancy is unchanged.
- Pointer wrap-around is modulo FIFO_DEPTH. The full/empty distinction uses an extra pointer bit.
- Reset mid-operation flushes all pending requests, suppresses any data_ok and returns to IDLE. A write not yet at the cnt == 0 edge is never performed.

Test Plan:
- Reset then idle: rst pulse, req = 0 for 10 cycles -> addr_ok = 0, data_ok = 0, rdata = 0 throughout.
- Word write then read, LATENCY = 2: write 0xDEADBEEF to 0x00000010 accepted at edge T -> data_ok at T+2. Read 0x00000010 accepted at T+1 -> data_ok at T+4 with rdata = 0xDEADBEEF.
- Byte/half merge: word 0x11223344 at 0x20, then byte write 0xAA in lane 1 (addr 0x21, size 0), then half write 0xBBCC in lanes 2-3 (addr 0x22, size 1) -> read 0x20 returns 0xBBCCAA44.
- Misaligned write: word write 0xFFFFFFFF to 0x32 after 0x12345678 stored at 0x30 -> data_ok pulses once; read 0x30 = 0x12345678.
- Backpressure, FIFO_DEPTH = 2, LATENCY = 4: req held high for 3 reads -> addr_ok high on the first 2 accepts, low until the first pop, 3rd accepted after it. data_ok pulses are exactly 4 cycles apart, in order.
- Reset mid-flight: a write accepted, rst asserted for 1 cycle before data_ok -> no data_ok ever appears; a later read of that address returns the old value.
